// File: rtl/sram_arbiter_pkg.sv
// Shared encodings for the instruction/data SRAM-port arbiter.
package sram_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_WAIT = 2'd2
  } arb_state_t;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  localparam logic OWNER_INST = 1'b0;
  localparam logic OWNER_DATA = 1'b1;

  // A cancel only matters while a fetch owns the port.
  function automatic logic fetch_cancel(input logic owner, input logic fs_cancel);
    return fs_cancel && (owner == OWNER_INST);
  endfunction

endpackage

// File: rtl/sram_arbiter.sv
// Arbitrates one SRAM-like memory port between instruction fetch and data
// access. Data has fixed priority, one transaction is outstanding at a time,
// and a cancelled fetch still completes on the memory side but its response
// is swallowed.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic                inst_addr_ok,
  output logic                inst_data_ok,
  output logic [DATA_W-1:0]   inst_rdata,
  input  logic                fs_cancel,
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [1:0]          data_size,
  input  logic [DATA_W/8-1:0] data_wstrb,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_addr_ok,
  output logic                data_data_ok,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                mem_req,
  output logic                mem_wr,
  output logic [1:0]          mem_size,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_addr_ok,
  input  logic                mem_data_ok,
  input  logic [DATA_W-1:0]   mem_rdata
);

  arb_state_t state, state_nxt;
  logic       owner, owner_nxt;
  logic       drop, drop_nxt;

  // Read data is broadcast; only the data_ok strobes qualify it.
  assign inst_rdata = mem_rdata;
  assign data_rdata = mem_rdata;

  // State, owner and drop-flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ARB_IDLE;
      owner <= OWNER_INST;
      drop  <= 1'b0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      drop  <= drop_nxt;
    end
  end

  // Next-state decode, payload forwarding and handshake routing.
  always_comb begin
    state_nxt    = state;
    owner_nxt    = owner;
    drop_nxt     = drop;
    mem_req      = 1'b0;
    mem_wr       = 1'b0;
    mem_size     = SZ_B;
    mem_wstrb    = '0;
    mem_addr     = '0;
    mem_wdata    = '0;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;

    unique case (state)
      ARB_IDLE: begin
        if (data_req) begin
          owner_nxt = OWNER_DATA;
          state_nxt = ARB_REQ;
        end else if (inst_req) begin
          owner_nxt = OWNER_INST;
          state_nxt = ARB_REQ;
        end
      end

      ARB_REQ: begin
        mem_req = 1'b1;
        if (owner == OWNER_DATA) begin
          mem_wr    = data_wr;
          mem_size  = data_size;
          mem_wstrb = data_wstrb;
          mem_addr  = data_addr;
          mem_wdata = data_wdata;
        end else begin
          mem_size  = SZ_W;
          mem_addr  = inst_addr;
        end
        if (mem_addr_ok) begin
          data_addr_ok = (owner == OWNER_DATA);
          inst_addr_ok = (owner == OWNER_INST);
          state_nxt    = ARB_WAIT;
        end
        if (fetch_cancel(owner, fs_cancel)) drop_nxt = 1'b1;
      end

      ARB_WAIT: begin
        if (mem_data_ok) begin
          // A cancel arriving with the response itself still drops it.
          data_data_ok = (owner == OWNER_DATA);
          inst_data_ok = (owner == OWNER_INST) && !drop && !fs_cancel;
          drop_nxt     = 1'b0;
          state_nxt    = ARB_IDLE;
        end else if (fetch_cancel(owner, fs_cancel)) begin
          drop_nxt = 1'b1;
        end
      end

      default: begin
        state_nxt = ARB_IDLE;
        drop_nxt  = 1'b0;
      end
    endcase
  end

endmodule
